// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master datapath.
package i2c_pkg;

    localparam int I2C_CNT_W     = 11;
    localparam int I2C_MIN_PHASE = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH_WAIT,
        HIGH
    } scl_state_t;

endpackage

// File: rtl/i2c_sync.sv
// Flop-chain synchroniser for an open-drain bus line; resets to 1 (idle bus).
module i2c_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic q_early
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q       = chain[STAGES-1];
    // One stage short: a consumer whose own register completes the synchroniser reads this tap.
    assign q_early = chain[STAGES-2];

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: open-drain SCL drive, phase ticks, clock stretching and multi-master sync.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int CNT_W       = I2C_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] lo_cnt,
    input  logic [CNT_W-1:0] hi_cnt,
    input  logic             scl_in,
    output logic             scl_oe,
    output logic             tick_fall,
    output logic             tick_drive,
    output logic             tick_rise,
    output logic             tick_sample,
    output logic             stretching,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MIN_PHASE     = CNT_W'(I2C_MIN_PHASE);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] STRETCH_AFTER = CNT_W'(SYNC_STAGES);

    scl_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] eff, eff_nxt;
    logic             scl_s, scl_early;
    logic             last_cnt;

    function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] v);
        return (v < MIN_PHASE) ? MIN_PHASE : v;
    endfunction

    // Rising SCL is taken from the early tap (state register is the last stage);
    // a pull-down in HIGH waits for the full-depth output before aborting.
    i2c_sync #(
        .STAGES (SYNC_STAGES)
    ) u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .d       (scl_in),
        .q       (scl_s),
        .q_early (scl_early)
    );

    assign last_cnt = (cnt == eff - CNT_ONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_ONE;
        eff_nxt   = eff;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    state_nxt = LOW;
                    eff_nxt   = clamp_phase(lo_cnt);
                end
            end
            LOW: begin
                if (last_cnt) begin
                    state_nxt = HIGH_WAIT;
                    cnt_nxt   = '0;
                end
            end
            HIGH_WAIT: begin
                if (scl_early) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    eff_nxt   = clamp_phase(hi_cnt);
                end else if (&cnt) begin
                    cnt_nxt = cnt;
                end
            end
            HIGH: begin
                if (!scl_s || (last_cnt && en)) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    eff_nxt   = clamp_phase(lo_cnt);
                end else if (last_cnt) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            eff         <= MIN_PHASE;
            scl_oe      <= 1'b0;
            busy        <= 1'b0;
            tick_fall   <= 1'b0;
            tick_drive  <= 1'b0;
            tick_rise   <= 1'b0;
            tick_sample <= 1'b0;
            stretching  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            eff         <= eff_nxt;
            scl_oe      <= (state_nxt == LOW);
            busy        <= (state_nxt != IDLE);
            tick_fall   <= (state_nxt == LOW) && (cnt_nxt == '0);
            tick_drive  <= (state_nxt == LOW) && (cnt_nxt == (eff_nxt >> 1));
            tick_rise   <= (state_nxt == HIGH) && (cnt_nxt == '0);
            // Suppressed once the bus is already seen low, so an aborted HIGH never samples.
            tick_sample <= (state_nxt == HIGH) && (cnt_nxt == (eff_nxt >> 1)) && scl_early;
            stretching  <= (state_nxt == HIGH_WAIT) && (cnt_nxt >= STRETCH_AFTER);
        end
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed self-checking bench for i2c_scl_gen with a wired-AND bus model.
module tb_i2c_scl_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [10:0] lo_cnt;
    logic [10:0] hi_cnt;
    logic        scl_in;
    logic        ext_low;
    logic        scl_oe, tick_fall, tick_drive, tick_rise, tick_sample, stretching, busy;

    int n_cmp;
    int n_err;
    int multi;

    localparam int BOUND = 100;

    i2c_scl_gen #(
        .CNT_W       (11),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .lo_cnt      (lo_cnt),
        .hi_cnt      (hi_cnt),
        .scl_in      (scl_in),
        .scl_oe      (scl_oe),
        .tick_fall   (tick_fall),
        .tick_drive  (tick_drive),
        .tick_rise   (tick_rise),
        .tick_sample (tick_sample),
        .stretching  (stretching),
        .busy        (busy)
    );

    // Open-drain bus with pull-up; another device may also hold it low.
    assign scl_in = ~scl_oe & ~ext_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int outs();
        return int'({scl_oe, busy, tick_fall, tick_drive, tick_rise, tick_sample, stretching});
    endfunction

    // Starts on a tick_fall cycle (offset 0) and records offsets up to the next tick_fall.
    task automatic measure(input int ext_on, input int ext_off,
                           output int drive, output int rise, output int sample,
                           output int fall, output int oe_len, output int str_len,
                           output int ticks);
        drive = -1; rise = -1; sample = -1; fall = -1;
        oe_len = int'(scl_oe); str_len = 0; ticks = 0;
        for (int k = 1; k <= BOUND; k++) begin
            if (k - 1 == ext_on)  ext_low = 1'b1;
            if (k - 1 == ext_off) ext_low = 1'b0;
            step();
            if (int'(tick_fall) + int'(tick_drive) + int'(tick_rise) + int'(tick_sample) > 1)
                multi++;
            if (tick_fall) begin
                fall = k;
                break;
            end
            if (scl_oe)     oe_len++;
            if (stretching) str_len++;
            if (tick_drive  && drive  < 0) drive  = k;
            if (tick_rise   && rise   < 0) rise   = k;
            if (tick_sample && sample < 0) sample = k;
            ticks += int'(tick_drive) + int'(tick_rise) + int'(tick_sample);
        end
        ext_low = 1'b0;
    endtask

    task automatic expect_period(input string tag, input int ext_on, input int ext_off,
                                 input int e_drive, input int e_rise, input int e_sample,
                                 input int e_fall, input int e_oe, input int e_str,
                                 input int e_ticks);
        int drive, rise, sample, fall, oe_len, str_len, ticks;
        measure(ext_on, ext_off, drive, rise, sample, fall, oe_len, str_len, ticks);
        check({tag, ".drive"},   drive,   e_drive);
        check({tag, ".rise"},    rise,    e_rise);
        check({tag, ".sample"},  sample,  e_sample);
        check({tag, ".period"},  fall,    e_fall);
        check({tag, ".oe_len"},  oe_len,  e_oe);
        check({tag, ".stretch"}, str_len, e_str);
        check({tag, ".ticks"},   ticks,   e_ticks);
    endtask

    initial begin
        int idle_at;
        int rise_at;
        n_cmp = 0; n_err = 0; multi = 0;
        rst = 1'b1; en = 1'b0; lo_cnt = 11'd10; hi_cnt = 11'd8; ext_low = 1'b0;

        step();
        step();
        check("reset.outs", outs(), 0);
        rst = 1'b0;
        step();
        check("idle.en0", outs(), 0);

        // IDLE -> LOW: scl_oe, busy, tick_fall one cycle after en is sampled.
        en = 1'b1;
        step();
        check("start.outs", outs(), 'h70);

        // LOW 10, HIGH_WAIT 2, HIGH 8.
        expect_period("free1", -1, -1, 5, 12, 16, 20, 10, 0, 3);
        expect_period("free2", -1, -1, 5, 12, 16, 20, 10, 0, 3);

        // Bus held low for 15 cycles after release: HIGH_WAIT 17 cycles.
        expect_period("stretch", 5, 25, 5, 27, 31, 35, 10, 15, 3);

        // Another master pulls SCL low at HIGH count 2: LOW re-entered 3 cycles later.
        expect_period("sync", 14, -1, 5, 12, -1, 17, 10, 0, 2);
        expect_period("post_sync", -1, -1, 5, 12, 16, 20, 10, 0, 3);

        // New counts given mid-LOW: this LOW keeps 10, the HIGH picks up the clamped 2.
        lo_cnt = 11'd0; hi_cnt = 11'd1;
        expect_period("mid_change", -1, -1, 5, 12, 13, 14, 10, 0, 3);
        expect_period("clamp", -1, -1, 1, 4, 5, 6, 2, 0, 3);

        // Drop en during LOW (eff=2 latched); HIGH latches hi_cnt=8 and then goes IDLE.
        lo_cnt = 11'd10; hi_cnt = 11'd8;
        step();
        en = 1'b0;
        idle_at = -1; rise_at = -1;
        for (int k = 2; k <= 60; k++) begin
            step();
            if (tick_rise && rise_at < 0) rise_at = k;
            if (!busy) begin
                idle_at = k;
                break;
            end
        end
        check("stop.rise", rise_at, 4);
        check("stop.idle_at", idle_at, 12);
        check("stop.outs", outs(), 0);
        step(); step(); step();
        check("stop.stay_idle", outs(), 0);

        // Reset at LOW count 4 with en held high.
        en = 1'b1;
        step();
        check("rst_test.start", outs(), 'h70);
        step(); step(); step(); step();
        check("rst_test.low4_oe", int'(scl_oe), 1);
        rst = 1'b1;
        step();
        check("rst_test.cleared", outs(), 0);
        rst = 1'b0;
        step();
        check("rst_test.restart", outs(), 'h70);

        check("ticks_exclusive", multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
